// File: rtl/vn_pkg.sv
// Shared definitions for the LDPC variable-node pipeline: default sizes,
// C2V input format encodings and small constant helper functions.
package vn_pkg;

  localparam int DEF_MSG_WIDTH = 6;
  localparam int DEF_PCM_ROWN  = 6;
  localparam int DEF_APP_WIDTH = 9;

  // Encoding of the C2V input bus format parameter.
  typedef enum int {
    C2V_FMT_TC = 0,   // two's complement
    C2V_FMT_SM = 1    // sign-magnitude
  } c2v_fmt_e;

  // Ceiling log2; used to size the exact-width adder tree result.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // Largest magnitude representable in a symmetric signed message of given width.
  function automatic int pos_max(input int width);
    return (32'sd1 << (width - 32'sd1)) - 32'sd1;
  endfunction

  // Most negative value of the symmetric range (the -2^(w-1) code is never produced).
  function automatic int neg_max(input int width);
    return -pos_max(width);
  endfunction

  localparam int POS_MAX = pos_max(DEF_MSG_WIDTH);
  localparam int NEG_MAX = neg_max(DEF_MSG_WIDTH);

endpackage

// File: rtl/vn_pipe_if.sv
// Beat interface of the variable-node pipeline: C2V/LLR input side and
// V2C/APP/hard-decision output side, with producer (master) and
// pipeline (slave) views.
interface vn_pipe_if
  import vn_pkg::*;
#(
  parameter int MSG_WIDTH = DEF_MSG_WIDTH,
  parameter int PCM_ROWN  = DEF_PCM_ROWN,
  parameter int APP_WIDTH = DEF_APP_WIDTH
);

  logic                          i_valid;
  logic                          i_stall;
  logic                          i_first;
  logic [PCM_ROWN-1:0]           i_edge_mask;
  logic [MSG_WIDTH-1:0]          i_llr;
  logic [MSG_WIDTH*PCM_ROWN-1:0] i_c2v_bus;

  logic                          o_valid;
  logic [MSG_WIDTH*PCM_ROWN-1:0] o_v2c_bus;
  logic [APP_WIDTH-1:0]          o_app;
  logic                          o_hd;

  modport master (
    output i_valid, i_stall, i_first, i_edge_mask, i_llr, i_c2v_bus,
    input  o_valid, o_v2c_bus, o_app, o_hd
  );

  modport slave (
    input  i_valid, i_stall, i_first, i_edge_mask, i_llr, i_c2v_bus,
    output o_valid, o_v2c_bus, o_app, o_hd
  );

endinterface

// File: rtl/vn_sat_sm.sv
// Combinational converter: two's complement value of any width to a
// MSG_WIDTH sign-magnitude message saturated to +/-(2^(MSG_WIDTH-1)-1).
// Zero always encodes as +0.
module vn_sat_sm
  import vn_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int MSG_WIDTH = DEF_MSG_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  din,
  output logic [MSG_WIDTH-1:0] dout
);

  localparam logic [IN_WIDTH-1:0] POS_MAX_W =
    {{(IN_WIDTH-MSG_WIDTH+1){1'b0}}, {(MSG_WIDTH-1){1'b1}}};

  // Within range the low bits of -din equal the negated low bits of din.
  logic [MSG_WIDTH-2:0] neg_mag_s;

  assign neg_mag_s = -din[MSG_WIDTH-2:0];

  // Clamp to the symmetric range, then split into sign and magnitude
  always_comb begin
    if ($signed(din) > $signed(POS_MAX_W)) begin
      dout = {1'b0, POS_MAX_W[MSG_WIDTH-2:0]};
    end else if ($signed(din) < -$signed(POS_MAX_W)) begin
      dout = {1'b1, POS_MAX_W[MSG_WIDTH-2:0]};
    end else if (din[IN_WIDTH-1]) begin
      dout = {1'b1, neg_mag_s};
    end else begin
      dout = {1'b0, din[MSG_WIDTH-2:0]};
    end
  end

endmodule

// File: rtl/vn_pipe.sv
// LDPC variable-node update, three register stages:
//   S1 C2V format conversion and first-iteration / edge-mask forcing,
//   S2 exact-width sum of channel LLR and all C2V messages,
//   S3 extrinsic V2C (sum minus own edge) saturated to sign-magnitude,
//      saturated APP LLR and hard decision.
// i_stall freezes every register; output data only changes on valid beats.
module vn_pipe
  import vn_pkg::*;
#(
  parameter int MSG_WIDTH = DEF_MSG_WIDTH,
  parameter int PCM_ROWN  = DEF_PCM_ROWN,
  parameter int APP_WIDTH = DEF_APP_WIDTH,
  parameter int C2V_FMT   = 0
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  vn_pipe_if.slave bus
);

  // Exact sum width: PCM_ROWN C2V terms plus the LLR can never overflow it.
  localparam int SUM_WIDTH  = MSG_WIDTH + clog2(PCM_ROWN + 1);
  localparam int DIFF_WIDTH = SUM_WIDTH + 1;
  localparam int APPW_WIDTH = ((SUM_WIDTH > APP_WIDTH) ? SUM_WIDTH : APP_WIDTH) + 1;

  localparam logic [APPW_WIDTH-1:0] APP_MAX_W =
    {{(APPW_WIDTH-APP_WIDTH+1){1'b0}}, {(APP_WIDTH-1){1'b1}}};
  localparam logic [APP_WIDTH-1:0] APP_POS_SAT = {1'b0, {(APP_WIDTH-1){1'b1}}};
  localparam logic [APP_WIDTH-1:0] APP_NEG_SAT = {1'b1, {(APP_WIDTH-2){1'b0}}, 1'b1};

  // ---------------- Stage 1 ----------------
  logic [MSG_WIDTH-1:0] c2v_raw_s [PCM_ROWN];
  logic [MSG_WIDTH-1:0] c2v_mag_s [PCM_ROWN];
  logic [MSG_WIDTH-1:0] c2v_tc_s  [PCM_ROWN];

  logic                 s1_valid_r;
  logic [MSG_WIDTH-1:0] s1_llr_r;
  logic [PCM_ROWN-1:0]  s1_mask_r;
  logic [MSG_WIDTH-1:0] s1_c2v_r [PCM_ROWN];

  // Convert each C2V to two's complement; absent edges and first iteration read as 0
  always_comb begin
    for (int k = 0; k < PCM_ROWN; k++) begin
      c2v_raw_s[k] = bus.i_c2v_bus[k*MSG_WIDTH +: MSG_WIDTH];
      c2v_mag_s[k] = {1'b0, c2v_raw_s[k][MSG_WIDTH-2:0]};
      if (bus.i_first || !bus.i_edge_mask[k]) begin
        c2v_tc_s[k] = '0;
      end else if (C2V_FMT == int'(C2V_FMT_SM)) begin
        // Negative zero negates to zero, so it needs no special case.
        if (c2v_raw_s[k][MSG_WIDTH-1]) begin
          c2v_tc_s[k] = -c2v_mag_s[k];
        end else begin
          c2v_tc_s[k] = c2v_mag_s[k];
        end
      end else begin
        c2v_tc_s[k] = c2v_raw_s[k];
      end
    end
  end

  // Stage 1 registers: converted C2V, channel LLR, edge mask and valid tag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_llr_r   <= '0;
      s1_mask_r  <= '0;
      for (int k = 0; k < PCM_ROWN; k++) begin
        s1_c2v_r[k] <= '0;
      end
    end else if (!bus.i_stall) begin
      s1_valid_r <= bus.i_valid;
      s1_llr_r   <= bus.i_llr;
      s1_mask_r  <= bus.i_edge_mask;
      for (int k = 0; k < PCM_ROWN; k++) begin
        s1_c2v_r[k] <= c2v_tc_s[k];
      end
    end
  end

  // ---------------- Stage 2 ----------------
  logic [SUM_WIDTH-1:0] sum_s;

  logic                 s2_valid_r;
  logic [SUM_WIDTH-1:0] s2_sum_r;
  logic [PCM_ROWN-1:0]  s2_mask_r;
  logic [MSG_WIDTH-1:0] s2_c2v_r [PCM_ROWN];

  // Single-stage adder tree: sign-extended LLR plus every C2V term
  always_comb begin
    sum_s = {{(SUM_WIDTH-MSG_WIDTH){s1_llr_r[MSG_WIDTH-1]}}, s1_llr_r};
    for (int k = 0; k < PCM_ROWN; k++) begin
      sum_s = sum_s + {{(SUM_WIDTH-MSG_WIDTH){s1_c2v_r[k][MSG_WIDTH-1]}}, s1_c2v_r[k]};
    end
  end

  // Stage 2 registers: full sum plus per-edge C2V needed for the extrinsic subtraction
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sum_r   <= '0;
      s2_mask_r  <= '0;
      for (int k = 0; k < PCM_ROWN; k++) begin
        s2_c2v_r[k] <= '0;
      end
    end else if (!bus.i_stall) begin
      s2_valid_r <= s1_valid_r;
      s2_sum_r   <= sum_s;
      s2_mask_r  <= s1_mask_r;
      for (int k = 0; k < PCM_ROWN; k++) begin
        s2_c2v_r[k] <= s1_c2v_r[k];
      end
    end
  end

  // ---------------- Stage 3 ----------------
  logic [DIFF_WIDTH-1:0]         diff_s   [PCM_ROWN];
  logic [MSG_WIDTH-1:0]          sat_sm_s [PCM_ROWN];
  logic [MSG_WIDTH*PCM_ROWN-1:0] v2c_s;
  logic [APPW_WIDTH-1:0]         app_wide_s;
  logic [APP_WIDTH-1:0]          app_s;

  logic                          o_valid_r;
  logic [MSG_WIDTH*PCM_ROWN-1:0] v2c_r;
  logic [APP_WIDTH-1:0]          app_r;
  logic                          hd_r;

  // Extrinsic value per edge: total sum minus that edge's own C2V
  always_comb begin
    for (int k = 0; k < PCM_ROWN; k++) begin
      diff_s[k] = {s2_sum_r[SUM_WIDTH-1], s2_sum_r}
                - {{(DIFF_WIDTH-MSG_WIDTH){s2_c2v_r[k][MSG_WIDTH-1]}}, s2_c2v_r[k]};
    end
  end

  for (genvar g = 0; g < PCM_ROWN; g++) begin : g_sat
    vn_sat_sm #(
      .IN_WIDTH  (DIFF_WIDTH),
      .MSG_WIDTH (MSG_WIDTH)
    ) u_sat (
      .din  (diff_s[g]),
      .dout (sat_sm_s[g])
    );
  end

  // Pack V2C messages; absent edges send +0
  always_comb begin
    v2c_s = '0;
    for (int k = 0; k < PCM_ROWN; k++) begin
      if (s2_mask_r[k]) begin
        v2c_s[k*MSG_WIDTH +: MSG_WIDTH] = sat_sm_s[k];
      end else begin
        v2c_s[k*MSG_WIDTH +: MSG_WIDTH] = '0;
      end
    end
  end

  assign app_wide_s = {{(APPW_WIDTH-SUM_WIDTH){s2_sum_r[SUM_WIDTH-1]}}, s2_sum_r};

  // Saturate the APP sum symmetrically into APP_WIDTH bits
  always_comb begin
    if ($signed(app_wide_s) > $signed(APP_MAX_W)) begin
      app_s = APP_POS_SAT;
    end else if ($signed(app_wide_s) < -$signed(APP_MAX_W)) begin
      app_s = APP_NEG_SAT;
    end else begin
      app_s = app_wide_s[APP_WIDTH-1:0];
    end
  end

  // Output registers: valid follows the pipe, data only refreshed by valid beats
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid_r <= 1'b0;
      v2c_r     <= '0;
      app_r     <= '0;
      hd_r      <= 1'b0;
    end else if (!bus.i_stall) begin
      o_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        v2c_r <= v2c_s;
        app_r <= app_s;
        hd_r  <= s2_sum_r[SUM_WIDTH-1];
      end else begin
        v2c_r <= v2c_r;
        app_r <= app_r;
        hd_r  <= hd_r;
      end
    end
  end

  assign bus.o_valid   = o_valid_r;
  assign bus.o_v2c_bus = v2c_r;
  assign bus.o_app     = app_r;
  assign bus.o_hd      = hd_r;

endmodule

// File: tb/tb_vn_pipe.sv
// Testbench for vn_pipe: one two's-complement and one sign-magnitude
// instance driven with identical beats, checked every cycle against an
// integer reference model and at directed points against fixed values.
module tb_vn_pipe;

  localparam int MW = 6;
  localparam int NR = 6;
  localparam int AW = 9;
  localparam int BW = MW * NR;

  typedef struct packed {
    logic [BW-1:0] v2c;
    logic [AW-1:0] app;
    logic          hd;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          v_valid;
  logic          v_stall;
  logic          v_first;
  logic [NR-1:0] v_mask;
  logic [MW-1:0] v_llr;
  logic [BW-1:0] v_c2v;

  int errors = 0;
  int checks = 0;
  int emitted = 0;

  // Expected-output model state
  int   pend_cnt [$];
  exp_t pend_tc  [$];
  exp_t pend_sm  [$];
  logic exp_valid;
  exp_t last_tc;
  exp_t last_sm;

  always #5 i_clk = ~i_clk;

  vn_pipe_if #(.MSG_WIDTH(MW), .PCM_ROWN(NR), .APP_WIDTH(AW)) bus_tc ();
  vn_pipe_if #(.MSG_WIDTH(MW), .PCM_ROWN(NR), .APP_WIDTH(AW)) bus_sm ();

  assign bus_tc.i_valid = v_valid;      assign bus_sm.i_valid = v_valid;
  assign bus_tc.i_stall = v_stall;      assign bus_sm.i_stall = v_stall;
  assign bus_tc.i_first = v_first;      assign bus_sm.i_first = v_first;
  assign bus_tc.i_edge_mask = v_mask;   assign bus_sm.i_edge_mask = v_mask;
  assign bus_tc.i_llr = v_llr;          assign bus_sm.i_llr = v_llr;
  assign bus_tc.i_c2v_bus = v_c2v;      assign bus_sm.i_c2v_bus = v_c2v;

  vn_pipe #(.MSG_WIDTH(MW), .PCM_ROWN(NR), .APP_WIDTH(AW), .C2V_FMT(0)) dut_tc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus_tc)
  );

  vn_pipe #(.MSG_WIDTH(MW), .PCM_ROWN(NR), .APP_WIDTH(AW), .C2V_FMT(1)) dut_sm (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus_sm)
  );

  function automatic int clamp(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Reference: integer arithmetic straight from the variable-node update rules
  function automatic exp_t ref_model(input int fmt, input logic [MW-1:0] llr,
                                     input logic [BW-1:0] c2v, input logic [NR-1:0] mask,
                                     input logic first);
    int c [NR];
    int sum;
    int v;
    logic [MW-1:0] raw;
    logic [MW-1:0] enc;
    exp_t r;
    sum = int'($signed(llr));
    for (int k = 0; k < NR; k++) begin
      raw = c2v[k*MW +: MW];
      if (fmt == 1) c[k] = raw[MW-1] ? -int'(raw[MW-2:0]) : int'(raw[MW-2:0]);
      else          c[k] = int'($signed(raw));
      if (first || !mask[k]) c[k] = 0;
      sum += c[k];
    end
    r.v2c = '0;
    for (int k = 0; k < NR; k++) begin
      v = clamp(sum - c[k], (1 << (MW-1)) - 1);
      enc = (v < 0) ? MW'((1 << (MW-1)) + (-v)) : MW'(v);
      if (mask[k]) r.v2c[k*MW +: MW] = enc;
    end
    r.app = AW'(clamp(sum, (1 << (AW-1)) - 1));
    r.hd  = (sum < 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("tc_valid", 64'(bus_tc.o_valid),   64'(exp_valid));
    chk("tc_v2c",   64'(bus_tc.o_v2c_bus), 64'(last_tc.v2c));
    chk("tc_app",   64'(bus_tc.o_app),     64'(last_tc.app));
    chk("tc_hd",    64'(bus_tc.o_hd),      64'(last_tc.hd));
    chk("sm_valid", 64'(bus_sm.o_valid),   64'(exp_valid));
    chk("sm_v2c",   64'(bus_sm.o_v2c_bus), 64'(last_sm.v2c));
    chk("sm_app",   64'(bus_sm.o_app),     64'(last_sm.app));
    chk("sm_hd",    64'(bus_sm.o_hd),      64'(last_sm.hd));
  endtask

  // One clock: drive inputs, advance the latency model, then compare 1 time unit after the edge
  task automatic cycle(input logic rst_n, input logic valid, input logic stall,
                       input logic first, input logic [NR-1:0] mask,
                       input logic [MW-1:0] llr, input logic [BW-1:0] c2v);
    exp_t e_tc;
    exp_t e_sm;
    i_rst_n = rst_n; v_valid = valid; v_stall = stall; v_first = first;
    v_mask = mask; v_llr = llr; v_c2v = c2v;
    e_tc = ref_model(0, llr, c2v, mask, first);
    e_sm = ref_model(1, llr, c2v, mask, first);
    @(posedge i_clk);
    if (!rst_n) begin
      pend_cnt.delete(); pend_tc.delete(); pend_sm.delete();
      exp_valid = 1'b0; last_tc = '0; last_sm = '0;
    end else if (!stall) begin
      exp_valid = 1'b0;
      foreach (pend_cnt[i]) pend_cnt[i]--;
      if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
        exp_valid = 1'b1;
        last_tc = pend_tc.pop_front();
        last_sm = pend_sm.pop_front();
        void'(pend_cnt.pop_front());
      end
      if (valid) begin
        pend_cnt.push_back(2); pend_tc.push_back(e_tc); pend_sm.push_back(e_sm);
      end
    end
    #1;
    if (rst_n && !stall && bus_tc.o_valid === 1'b1) emitted++;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  logic [MW-1:0] b_llr  [10];
  logic [BW-1:0] b_c2v  [10];
  logic [NR-1:0] b_mask [10];

  initial begin
    logic [BW-1:0] c;
    int b;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("reset_valid", 64'(bus_tc.o_valid), 64'd0);
    chk("reset_app",   64'(bus_tc.o_app),   64'd0);

    // Basic beat: llr=+5, c2v={1,2,3,-4,0,-1}
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 6'd5,
          {6'h3F, 6'h00, 6'h3C, 6'h03, 6'h02, 6'h01});
    idle(); idle();
    chk("basic_valid", 64'(bus_tc.o_valid), 64'd1);
    chk("basic_v2c", 64'(bus_tc.o_v2c_bus), 64'({6'd7, 6'd6, 6'd10, 6'd3, 6'd4, 6'd5}));
    chk("basic_app", 64'(bus_tc.o_app), 64'd6);
    chk("basic_hd",  64'(bus_tc.o_hd),  64'd0);
    idle();
    chk("basic_one_cycle", 64'(bus_tc.o_valid), 64'd0);
    chk("basic_hold_app",  64'(bus_tc.o_app),   64'd6);

    // Positive saturation
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h1F, {6{6'h1F}});
    idle(); idle();
    chk("satp_v2c", 64'(bus_tc.o_v2c_bus), 64'({6{6'h1F}}));
    chk("satp_app", 64'(bus_tc.o_app), 64'd217);
    chk("satp_hd",  64'(bus_tc.o_hd),  64'd0);

    // Negative saturation
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h21, {6{6'h21}});
    idle(); idle();
    chk("satn_v2c", 64'(bus_tc.o_v2c_bus), 64'({6{6'h3F}}));
    chk("satn_app", 64'(bus_tc.o_app), 64'h127);
    chk("satn_hd",  64'(bus_tc.o_hd),  64'd1);

    // First iteration: C2V ignored, every V2C is the LLR
    c = {$urandom, $urandom};
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 6'h3F, 6'h39, c);
    idle(); idle();
    chk("first_v2c", 64'(bus_tc.o_v2c_bus), 64'({6{6'h27}}));
    chk("first_app", 64'(bus_tc.o_app), 64'h1F9);

    // Partial mask: edges 0 and 2 only
    c = {$urandom, $urandom};
    c[5:0] = 6'd2;
    c[17:12] = 6'd3;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h05, 6'h39, c);
    idle(); idle();
    chk("mask_v2c", 64'(bus_tc.o_v2c_bus), 64'({6'h00, 6'h00, 6'h00, 6'h25, 6'h00, 6'h24}));
    chk("mask_app", 64'(bus_tc.o_app), 64'h1FE);

    // Sign-magnitude input with negative zero
    c = {$urandom, $urandom};
    c[5:0] = 6'h20;
    c[11:6] = 6'h23;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h03, 6'h01, c);
    idle(); idle();
    chk("sm_v2c_dir", 64'(bus_sm.o_v2c_bus), 64'({6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h22}));
    chk("sm_app_dir", 64'(bus_sm.o_app), 64'h1FE);
    chk("sm_hd_dir",  64'(bus_sm.o_hd),  64'd1);

    // All-zero mask: APP is the LLR, V2C all zero
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 6'h33, {$urandom, $urandom});
    idle(); idle();
    chk("mask0_v2c", 64'(bus_tc.o_v2c_bus), 64'd0);
    chk("mask0_app", 64'(bus_tc.o_app), 64'h1F3);

    // Stream of 10 beats with a 2-cycle stall; producer holds the beat while stalled
    for (int i = 0; i < 10; i++) begin
      b_llr[i] = MW'($urandom); b_c2v[i] = {$urandom, $urandom}; b_mask[i] = NR'($urandom);
    end
    idle(); idle(); idle();
    emitted = 0;
    b = 0;
    for (int t = 0; t < 12; t++) begin
      if (t == 5 || t == 6) cycle(1'b1, 1'b1, 1'b1, 1'b0, b_mask[b], b_llr[b], b_c2v[b]);
      else begin
        cycle(1'b1, 1'b1, 1'b0, 1'b0, b_mask[b], b_llr[b], b_c2v[b]);
        b++;
      end
    end
    for (int t = 0; t < 4; t++) idle();
    chk("stream_count", 64'(emitted), 64'd10);

    // Reset with two beats in flight
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 6'd9, {$urandom, $urandom});
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 6'd11, {$urandom, $urandom});
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 6'h3F, 6'd13, {$urandom, $urandom});
    chk("rst_mid_valid", 64'(bus_tc.o_valid),   64'd0);
    chk("rst_mid_app",   64'(bus_tc.o_app),     64'd0);
    chk("rst_mid_v2c",   64'(bus_tc.o_v2c_bus), 64'd0);
    emitted = 0;
    for (int t = 0; t < 4; t++) idle();
    chk("rst_no_leak", 64'(emitted), 64'd0);

    // Randomized traffic with bubbles, stalls, first-iteration beats and masks
    for (int t = 0; t < 200; t++) begin
      cycle(1'b1, ($urandom_range(3) != 0), ($urandom_range(7) == 0),
            ($urandom_range(5) == 0),
            ($urandom_range(9) == 0) ? NR'(0) : NR'($urandom),
            MW'($urandom), {$urandom, $urandom});
    end
    for (int t = 0; t < 5; t++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
